// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with a valid/ready load port.
// New values are swapped in only on frame wrap so a scan never shows a mixed frame.
module seg7_scan_driver #(
  parameter int N              = 4,
  parameter int DIV            = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*N-1:0] value,
  input  logic [N-1:0]   dp_in,
  input  logic           hex_mode,
  input  logic           blank_lz,
  output logic [6:0]     seg,
  output logic           dp,
  output logic [N-1:0]   dig
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [6:0]   SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic         DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [N-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [4*N-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [N-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic           pending_q, pending_d;
  logic           in_ready_q, in_ready_d;
  logic           lit_q, lit_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic [N-1:0]   dig_q, dig_d;

  logic           tick, wrap, accept;
  logic [3:0]     nib;
  logic           dp_bit, zeros_above, lz_blank;
  logic [6:0]     seg_al;
  logic [N-1:0]   dig_oh;

  // Glyphs in active-low form (0 = segment lit), order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;  4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;  4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;  4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;  4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0001100;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;  4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;  default: glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_val_d   = sh_val_q;
    sh_dp_d    = sh_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pending_d  = pending_q;
    tick       = (cnt_q == CW'(DIV - 1));
    wrap       = tick && (idx_q == IW'(N - 1));
    accept     = in_valid && in_ready_q;

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

    // Transfer uses the old pending flag, so a same-cycle accept waits a frame.
    if (wrap && pending_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      sh_val_d  = value;
      sh_dp_d   = dp_in;
      pending_d = 1'b1;
    end
    in_ready_d = !pending_d;
    lit_d      = lit_q || tick;

    nib         = '0;
    dp_bit      = 1'b0;
    zeros_above = 1'b1;
    lz_blank    = 1'b0;
    dig_oh      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      zeros_above = zeros_above && (act_val_d[4*i +: 4] == 4'h0);
      dig_oh[i]   = (idx_d == IW'(i));
      if (idx_d == IW'(i)) begin
        nib      = act_val_d[4*i +: 4];
        dp_bit   = act_dp_d[i];
        lz_blank = blank_lz && (i != 0) && zeros_above;
      end
    end

    seg_al = glyph(nib);
    if (lz_blank || (!hex_mode && nib > 4'd9)) seg_al = 7'h7F;

    seg_d = lit_d ? ((SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al) : SEG_OFF;
    dp_d  = lit_d ? ((SEG_ACTIVE_LOW != 0) ? ~dp_bit : dp_bit) : DP_OFF;
    dig_d = lit_d ? ((DIG_ACTIVE_LOW != 0) ? ~dig_oh : dig_oh) : DIG_OFF;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pending_q  <= 1'b0;
      in_ready_q <= 1'b0;
      lit_q      <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      dig_q      <= DIG_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      pending_q  <= pending_d;
      in_ready_q <= in_ready_d;
      lit_q      <= lit_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
    end
  end

  assign in_ready = in_ready_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign dig      = dig_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic, every cycle
// compared against a tick-count/frame arithmetic model of the display.
module tb_seg7_scan_driver;
  localparam int N   = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        hex_mode = 1'b1;
  logic        blank_lz = 1'b0;
  logic        in_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N(N), .DIV(DIV), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .value(value), .dp_in(dp_in), .hex_mode(hex_mode), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .dig(dig)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  logic [6:0] glyph_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model: k = clock edges since reset release; ticks happen every DIV edges,
  // the shown digit is (ticks mod N), a frame ends when ticks hits a multiple of N.
  int          k = 0;
  logic        m_pend = 1'b0, m_rdy = 1'b0, m_lit = 1'b0;
  logic [15:0] m_sh_v = '0, m_act_v = '0;
  logic [3:0]  m_sh_dp = '0, m_act_dp = '0;

  function automatic int cur_idx();
    return (k / DIV) % N;
  endfunction

  task automatic step();
    logic r, v, hx, lz, acc, tck, wrp, blank;
    logic [15:0] val, above;
    logic [3:0]  dpi, nib;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_dig;
    int          ix;
    r = nreset; v = in_valid; val = value; dpi = dp_in; hx = hex_mode; lz = blank_lz;
    @(posedge clk);
    if (!r) begin
      k = 0; m_pend = 0; m_rdy = 0; m_lit = 0;
      m_sh_v = '0; m_sh_dp = '0; m_act_v = '0; m_act_dp = '0;
    end else begin
      acc = v && m_rdy;
      k++;
      tck = (k % DIV) == 0;
      wrp = tck && ((k / DIV) % N) == 0;
      if (wrp && m_pend) begin
        m_act_v = m_sh_v; m_act_dp = m_sh_dp; m_pend = 0;
      end
      if (acc) begin
        m_sh_v = val; m_sh_dp = dpi; m_pend = 1;
      end
      m_rdy = !m_pend;
      if (tck) m_lit = 1;
    end
    #1;
    if (!m_lit) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
    end else begin
      ix    = cur_idx();
      above = m_act_v >> (4 * ix);
      nib   = above[3:0];
      blank = (!hx && nib > 4'd9) || (lz && ix > 0 && above == 16'h0);
      e_seg = blank ? 7'h7F : glyph_tbl[nib];
      e_dp  = ~m_act_dp[ix];
      e_dig = ~(4'b0001 << ix);
    end
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
    chk("seg", {25'b0, seg}, {25'b0, e_seg});
    chk("dp", {31'b0, dp}, {31'b0, e_dp});
    chk("dig", {28'b0, dig}, {28'b0, e_dig});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer a value and hold in_valid until it is taken (bounded).
  task automatic load(input logic [15:0] v, input logic [3:0] d);
    logic taken;
    int   t;
    taken = 1'b0;
    in_valid = 1'b1; value = v; dp_in = d;
    for (t = 0; t < 200 && !taken; t++) begin
      taken = m_rdy;
      step();
    end
    in_valid = 1'b0;
    chk("load_timeout", {31'b0, taken}, 32'd1);
  endtask

  // Step until the model reports the requested condition, bounded.
  task automatic wait_edge_before_wrap();
    int t;
    for (t = 0; t < 100 && !(m_rdy && ((k + 1) % (N * DIV)) == 0); t++) step();
    chk("wrap_wait_timeout", {31'b0, (t < 100)}, 32'd1);
  endtask

  initial begin
    run(3);
    nreset = 1'b1;
    run(6);

    load(16'h1234, 4'b0100);
    run(40);

    load(16'hABCD, 4'b0000);
    run(40);
    hex_mode = 1'b0;
    run(20);
    hex_mode = 1'b1;

    blank_lz = 1'b1;
    load(16'h0050, 4'b0001);
    run(40);
    load(16'h0000, 4'b1000);
    run(40);
    blank_lz = 1'b0;

    load(16'h1111, 4'b0000);
    load(16'h2222, 4'b1111);
    run(40);

    // Offer exactly on the wrap edge: the value must wait one more frame.
    wait_edge_before_wrap();
    in_valid = 1'b1; value = 16'h9876; dp_in = 4'b0010;
    step();
    in_valid = 1'b0;
    run(40);

    // Reset while a value is pending and digit 2 is lit.
    begin
      int t;
      for (t = 0; t < 100 && !(cur_idx() == 0 && (k % DIV) == 1); t++) step();
      load(16'h4321, 4'b1010);
      for (t = 0; t < 100 && !(m_pend && cur_idx() == 2); t++) step();
      chk("idx2_wait_timeout", {31'b0, (t < 100)}, 32'd1);
    end
    nreset = 1'b0;
    run(2);
    nreset = 1'b1;
    run(40);

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom % 4) == 0;
      value    = 16'($urandom) & (16'hFFFF >> (4 * ($urandom % 4)));
      dp_in    = 4'($urandom);
      if ($urandom % 50 == 0) hex_mode = ~hex_mode;
      if ($urandom % 50 == 0) blank_lz = ~blank_lz;
      nreset   = ($urandom % 400) != 0;
      step();
    end
    in_valid = 1'b0;
    nreset = 1'b1;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
